// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter feeding one shared synchronous FIFO.
// Optional burst lock: define FIFO_WR_ARB_LOCK_EN.
module fifo_wr_arb #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int DEPTH     = 8,
  parameter int CW        = 4,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic              fifo_wr,
  output logic [DW-1:0]     fifo_data,
  input  logic              fifo_rd,
  output logic [CW-1:0]     occ,
  output logic              full
);

  localparam int PW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("fifo_wr_arb: NREQ out of range");
  end
  if ((1 << CW) <= DEPTH) begin : g_bad_cw
    $error("fifo_wr_arb: CW cannot hold DEPTH");
  end
  if (MAX_BURST < 1) begin : g_bad_burst
    $error("fifo_wr_arb: MAX_BURST must be >= 1");
  end

  logic [PW-1:0] rr_q, rr_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [PW-1:0] win_idx, sel_idx;
  logic [PW:0]   pos;
  logic          win_vld, sel_vld;
  logic          space, take;

  // cyclic search starting at the round-robin pointer
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    pos     = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = {1'b0, rr_q} + (PW+1)'(k);
      if (pos >= (PW+1)'(NREQ)) begin
        pos = pos - (PW+1)'(NREQ);
      end
      if (!win_vld && req[pos[PW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = pos[PW-1:0];
      end
    end
  end

`ifdef FIFO_WR_ARB_LOCK_EN
  localparam int BW = $clog2(MAX_BURST + 1);

  logic [BW-1:0] burst_q, burst_d, burst_n;
  logic [PW-1:0] own_q, own_d;
  logic          hold;

  assign hold    = (burst_q != '0) && req[own_q];
  assign sel_idx = hold ? own_q : win_idx;
  assign sel_vld = hold || win_vld;

  always_comb begin
    burst_d = burst_q;
    own_d   = own_q;
    burst_n = (hold ? burst_q : '0) + BW'(1);
    if (take) begin
      if (burst_n >= BW'(MAX_BURST)) begin
        burst_d = '0;
      end else begin
        burst_d = burst_n;
        own_d   = sel_idx;
      end
    end else if (!hold) begin
      burst_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_q <= '0;
      own_q   <= '0;
    end else begin
      burst_q <= burst_d;
      own_q   <= own_d;
    end
  end
`else
  assign sel_idx = win_idx;
  assign sel_vld = win_vld;
`endif

  assign space = occ_q < CW'(DEPTH);
  assign take  = sel_vld && space && !rst;
  assign gnt   = take ? (NREQ'(1) << sel_idx) : '0;
  assign occ   = occ_q;
  assign full  = occ_q == CW'(DEPTH);

  always_comb begin
    rr_d = rr_q;
    if (take) begin
      rr_d = (sel_idx == PW'(NREQ - 1)) ? '0 : sel_idx + PW'(1);
    end
  end

  // a read at zero is a consumer bug; hold at zero rather than wrap
  always_comb begin
    occ_d = occ_q;
    unique case (1'b1)
      take && !fifo_rd: occ_d = occ_q + CW'(1);
      !take && fifo_rd: occ_d = (occ_q == '0) ? '0 : occ_q - CW'(1);
      default:          occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q      <= '0;
      occ_q     <= '0;
      fifo_wr   <= 1'b0;
      fifo_data <= '0;
    end else begin
      rr_q    <= rr_d;
      occ_q   <= occ_d;
      fifo_wr <= take;
      if (take) begin
        fifo_data <= req_data[sel_idx*DW +: DW];
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(fifo_rd && occ_q == '0))
        else $error("fifo_wr_arb: fifo_rd with occ==0");
    end
  end
`endif

endmodule

// File: doc/fifo_wr_arb.md
Name: fifo_wr_arb

Overview:
- Round-robin write arbiter that shares one 8-bit synchronous FIFO (8 deep, 4-bit count) among NREQ requesters.
- Per cycle, grants at most one requester and drives the FIFO wr/data_in pins from registered outputs.
- Keeps a shadow occupancy counter so the FIFO is never written when full; no dependence on the FIFO's own fifo_cnt timing.
- Sits between client blocks and the fifo instance; the FIFO read side is owned by the consumer.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 8, data width
- DEPTH, 8, FIFO depth in words
- CW, 4, occupancy counter width (must hold DEPTH)
- MAX_BURST, 4, max consecutive grants to one requester (used only with FIFO_WR_ARB_LOCK_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- req  in  NREQ  per-requester write request; held with data until granted
- req_data  in  NREQ*DW  packed data; requester i uses bits [i*DW +: DW]
- gnt  out  NREQ  combinational one-hot accept; req[i]&gnt[i] at a rising edge = word taken
- fifo_wr  out  1  registered write strobe to FIFO wr
- fifo_data  out  DW  registered write data to FIFO data_in
- fifo_rd  in  1  qualified FIFO read (consumer guarantees FIFO non-empty)
- occ  out  CW  shadow occupancy (committed writes minus reads)
- full  out  1  occ == DEPTH

Behaviour:
- Reset (async, rst=1): fifo_wr=0, fifo_data=0, occ=0, full=0, rr pointer=0 (requester 0 highest priority), burst count=0. gnt forced to 0 while rst=1.
- Arbitration (combinational):
  - If occ<DEPTH and any req is high, gnt = first requester at or after rr pointer, searched cyclically.
  - Otherwise gnt=0. No read bypass: occ==DEPTH with fifo_rd=1 still gives gnt=0 that cycle.
- Handshake: the requester holds req and data stable until gnt is seen high at a rising edge, then may present the next word or drop req. gnt never asserts for a requester with req=0.
- Write path (1-cycle latency): on an edge with a grant, fifo_wr<=1 and fifo_data<=winner's data. Otherwise fifo_wr<=0 and fifo_data holds its last value.
- Pointer: after a grant to i, rr<=(i+1) mod NREQ. Pointer unchanged when there is no grant.
- Occupancy: occ_next = occ + grant - fifo_rd.
  - Grant and fifo_rd in the same cycle: occ unchanged.
  - fifo_rd with occ==0 is illegal; occ saturates at 0 and a simulation error is reported.
- FIFO safety: FIFO actual count lags occ by at most 1 write, so it never exceeds DEPTH. full is a combinational decode of occ.
- Reset mid-operation: an in-flight fifo_wr is dropped (forced 0). Requesters must resubmit. The FIFO is reset on the same rst.

Optional Feature:
- Macro: FIFO_WR_ARB_LOCK_EN.
- Defined: after a grant to i, the grant stays with i while req[i] stays high and space exists, up to MAX_BURST consecutive grants. The pointer then moves to i+1 and the burst count clears. Dropping req ends the burst early, and the pointer moves to i+1.
- Undefined: pure round robin; pointer advances after every grant; burst logic absent.

Test Plan:
- Reset, then req[0]=1 only, data 0,5,...,35 updated on each gnt -> gnt[0] high 8 consecutive cycles; fifo_wr high 1 cycle later with fifo_data 0..35; occ counts 1..8; full=1; 9th word not granted.
- All 4 req high, occ=0 -> grant order 0,1,2,3,0,1,2,3; fifo_wr continuous; occ=8 after 8 cycles.
- occ=8, req[2] high, fifo_rd pulse 1 cycle -> no gnt in the rd cycle; occ=7 next cycle; gnt[2] the following cycle; occ back to 8.
- occ=5, grant and fifo_rd in the same cycle -> occ stays 5; fifo_wr=1 next cycle.
- rst asserted mid-stream at occ=3 with fifo_wr=1 -> all outputs 0 immediately (async); after release, req[1]&req[3] -> first grant to 1.
- With FIFO_WR_ARB_LOCK_EN, MAX_BURST=4, req[0] and req[1] held -> grants 0,0,0,0,1,1,1,1; without the macro -> 0,1,0,1.
